// File: rtl/dmem_bridge.sv
// Data-memory bridge between the LSU and a req/ack memory port: aligns the address, builds byte
// enables and lane-replicated store data, stalls until ack, and flags misalignment and timeouts.
module dmem_bridge #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        acc_valid_i,
    input  logic [31:0] address_i,
    input  logic [3:0]  sel_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;

    logic        sel_word, sel_half, sel_byte;
    logic        acc, mis, start;
    logic [1:0]  off;
    logic [3:0]  be_lane;
    logic [31:0] wd_lane;

    assign sel_word = (sel_i == 4'b0001);
    assign sel_half = (sel_i == 4'b0010);
    assign sel_byte = (sel_i == 4'b0100);
    assign off      = address_i[1:0];
    assign acc      = acc_valid_i && (sel_word || sel_half || sel_byte);
    assign mis      = acc && ((sel_word && (off != 2'b00)) || (sel_half && off[0]));
    assign start    = acc && !mis;

    always_comb begin
        be_lane = 4'b0000;
        wd_lane = 32'h0;
        if (sel_word) begin
            be_lane = 4'b1111;
            wd_lane = wdata_i;
        end else if (sel_half) begin
            be_lane = off[1] ? 4'b1100 : 4'b0011;
            wd_lane = {2{wdata_i[15:0]}};
        end else if (sel_byte) begin
            be_lane = 4'b0001 << off;
            wd_lane = {4{wdata_i[7:0]}};
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_REQ;
                    mem_req_d   = 1'b1;
                    count_d     = '0;
                    mem_we_d    = write_i;
                    mem_be_d    = be_lane;
                    mem_addr_d  = {address_i[31:2], 2'b00};
                    mem_wdata_d = wd_lane;
                end
            end
            ST_REQ: begin
                // ack takes priority over a timeout landing in the same cycle
                if (mem_ack_i) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = 32'h0;
                    state_d   = ST_ERR;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                mem_be_d = 4'b0000;
                mem_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
            ST_ERR: begin
                bus_err_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign stall_o     = !rst_i && ((state_q == ST_IDLE && start) || state_q == ST_REQ);
    assign misalign_o  = !rst_i && mis;
    assign rdata_o     = rdata_q;
    assign bus_err_o   = bus_err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
